seq_mdu_alu: RTL
================

# seq_mdu_alu

Parametrised, handshaked successor to the 32-bit combinational ALU. It keeps the eight single-cycle operations and adds iterative signed/unsigned multiply and divide with a HI/LO result pair. It sits in the MIPS execute stage between operand read and writeback, and stalls issue through a valid/ready handshake while a multi-cycle operation runs.

## Interface
- WIDTH, 32: operand/result width, ≥4, even.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. The block uses one clock; reset is asynchronous and active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request (high only in IDLE).
- cmd  in  4  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12–15 illegal.
- op_a, op_b  in  WIDTH  operands, two's complement for signed commands.
- out_valid  out  1  result registers hold a completed operation.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  ALU result, product low half, or quotient.
- hi  out  WIDTH  product high half or remainder; 0 for cmd 0–7.
- carryout, overflow, zero, div_by_zero  out  1 each  status flags.

## Operation
- States: IDLE, MUL, DIV, DONE.
  - IDLE: a request is accepted when in_valid && in_ready. At acceptance the block captures op_a, op_b and cmd. Later input changes are ignored.
  - cmd 0–7 and 12–15 go to DONE. cmd 8/9 go to MUL and cmd 10/11 go to DIV, each with an iteration counter loaded to WIDTH.
  - MUL/DIV: one iteration per cycle. When the counter reaches 0, apply the sign fixup and go to DONE.
  - DONE: out_valid=1 and outputs hold stable. On out_ready go to IDLE.
- ADD/SUB: result = a±b mod 2^WIDTH.
  - carryout is the MSB carry of a+b, or of a+~b+1 for SUB.
  - overflow is set on signed overflow.
- SLT: result = (a<b signed) ? 1 : 0, correct even when a−b overflows.
  - overflow and carryout reflect the internal a−b.
- Logic ops (XOR, AND, NAND, NOR, OR): bitwise result; carryout=overflow=0.
- MULT/MULTU: {hi,result} is the full 2·WIDTH-bit product.
  - Algorithm: unsigned shift-add on magnitudes, product negated if operand signs differ (MULT only).
  - overflow=1 if the product does not fit in WIDTH bits: hi is not the sign-extension of result[WIDTH-1] (MULT), or hi≠0 (MULTU).
- DIV/DIVU: restoring division on magnitudes.
  - Quotient sign = sign(a)^sign(b); remainder sign follows the dividend (truncating division).
  - DIV of MIN by −1: result=MIN, hi=0, overflow=1.
- Divide by zero (b=0): div_by_zero=1, result all ones, hi=a, overflow=0. Latency is unchanged.
- Illegal cmd: result=hi=0, all flags 0, single-cycle latency.
- zero = (result==0) for every command. hi is ignored.
- Flags not defined for a command are 0.

## Timing
- Reset (async assert, any state, including mid-iteration): state IDLE, in_ready=1 after release. out_valid, result, hi and all flags are 0. Any in-flight operation is discarded.
- Latency from the accepting edge to out_valid high:
  - cmd 0–7 and illegal: 1 cycle.
  - MUL and DIV: WIDTH+1 cycles.
- in_ready=0 from the accepting edge until the out_valid&&out_ready edge.
- Maximum throughput is one operation per 2 cycles for single-cycle commands.
- out_valid stays high with outputs frozen until out_ready. Backpressure of any length must not corrupt the result.
- in_valid during MUL/DIV/DONE has no effect; the requester must hold the request.
- All outputs except in_ready are registered. in_ready is decoded from state only, with no combinational path from in_valid or out_ready.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+1: out_valid 1 cycle after accept, result 0x80000000, overflow=1, carryout=0. Then SLT 0x7FFFFFFF vs −3: result 0, overflow=1.
- MULT −3×7: out_valid exactly 33 cycles after accept, {hi,result}=0xFFFFFFFF_FFFFFFEB, overflow=0. MULTU 0xFFFFFFFF×2: hi=1, result=0xFFFFFFFE, overflow=1.
- DIV −7÷2: result=−3 (0xFFFFFFFD), hi=−1. DIVU 100÷7: result=14, hi=2. DIV 0x80000000÷−1: result 0x80000000, hi=0, overflow=1.
- DIVU 5÷0: div_by_zero=1, result=0xFFFFFFFF, hi=5, latency 33. SUB 100−100: result 0, zero=1, carryout=1.
- Hold out_ready=0 for 20 cycles after a MULT completes: outputs stable and in_ready=0 throughout. Pulse in_valid with new operands meanwhile: ignored. Release out_ready: IDLE the next cycle.
- Assert rst_n low at iteration 10 of a DIV: all outputs 0 immediately, in_ready=1 after release. The next ADD 2+1 returns 3 with latency 1.
- Repeat the MULT and DIV scenarios at WIDTH=8 (e.g. MULT −128×−1: {hi,result}=0x0080, overflow=1; latency 9).

Source files
------------

// File: rtl/seq_mdu_alu_if.sv
// Request/response bundle for seq_mdu_alu: command and operands in, registered result and status flags out.
// Both directions use valid/ready; the master side is the issuing/consuming pipeline stage.
interface seq_mdu_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output in_valid, cmd, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, hi, carryout, overflow, zero, div_by_zero
  );

  modport slave (
    input  in_valid, cmd, op_a, op_b, out_ready,
    output in_ready, out_valid, result, hi, carryout, overflow, zero, div_by_zero
  );
endinterface

// File: rtl/seq_mdu_alu.sv
// Execute-stage ALU with iterative mul/div; latency 1 cycle (ALU/illegal) or WIDTH+1 (mul/div).
// Accepts only in IDLE; the result is held frozen in DONE until out_ready, stalling issue meanwhile.
module seq_mdu_alu #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mdu_alu_if.slave alu_io
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] C_ADD  = 4'd0,  C_SUB   = 4'd1,  C_XOR = 4'd2,  C_SLT  = 4'd3;
  localparam logic [3:0] C_AND  = 4'd4,  C_NAND  = 4'd5,  C_NOR = 4'd6,  C_OR   = 4'd7;
  localparam logic [3:0] C_MULT = 4'd8,  C_MULTU = 4'd9,  C_DIV = 4'd10, C_DIVU = 4'd11;
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] mag_q, mag_d, acc_q, acc_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             co_q, co_d, ov_q, ov_d, zero_q, zero_d, dbz_q, dbz_d;

  // Single-cycle ALU on the live request operands
  logic [WIDTH:0]   add_w, sub_w;
  logic             add_ov, sub_ov, alu_co, alu_ov;
  logic [WIDTH-1:0] alu_res;

  assign add_w  = {1'b0, alu_io.op_a} + {1'b0, alu_io.op_b};
  assign sub_w  = {1'b0, alu_io.op_a} + {1'b0, ~alu_io.op_b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ov = (alu_io.op_a[WIDTH-1] == alu_io.op_b[WIDTH-1]) && (add_w[WIDTH-1] != alu_io.op_a[WIDTH-1]);
  assign sub_ov = (alu_io.op_a[WIDTH-1] != alu_io.op_b[WIDTH-1]) && (sub_w[WIDTH-1] != alu_io.op_a[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_co  = 1'b0;
    alu_ov  = 1'b0;
    case (alu_io.cmd)
      C_ADD:  begin alu_res = add_w[WIDTH-1:0]; alu_co = add_w[WIDTH]; alu_ov = add_ov; end
      C_SUB:  begin alu_res = sub_w[WIDTH-1:0]; alu_co = sub_w[WIDTH]; alu_ov = sub_ov; end
      // sign of a-b corrected by the overflow bit gives the true signed compare
      C_SLT:  begin
        alu_res = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1] ^ sub_ov};
        alu_co  = sub_w[WIDTH];
        alu_ov  = sub_ov;
      end
      C_XOR:  alu_res = alu_io.op_a ^ alu_io.op_b;
      C_AND:  alu_res = alu_io.op_a & alu_io.op_b;
      C_NAND: alu_res = ~(alu_io.op_a & alu_io.op_b);
      C_NOR:  alu_res = ~(alu_io.op_a | alu_io.op_b);
      C_OR:   alu_res = alu_io.op_a | alu_io.op_b;
      default: ;
    endcase
  end

  // Operand magnitudes for the iterative engines (cmd bit 0 clear = signed variant)
  logic             in_sgn;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  assign in_sgn   = ~alu_io.cmd[0];
  assign mag_a_in = (in_sgn && alu_io.op_a[WIDTH-1]) ? -alu_io.op_a : alu_io.op_a;
  assign mag_b_in = (in_sgn && alu_io.op_b[WIDTH-1]) ? -alu_io.op_b : alu_io.op_b;

  // Shift-add step: {acc,lo} shifts right, adding the multiplicand when lo[0] is set
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_raw, prod_fx;
  logic               mul_ov;

  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
  assign prod_raw = {mul_sum, lo_q[WIDTH-1:1]};
  assign prod_fx  = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -prod_raw : prod_raw;
  assign mul_ov   = sgn_q ? (prod_fx[2*WIDTH-1:WIDTH] != {WIDTH{prod_fx[WIDTH-1]}})
                          : (prod_fx[2*WIDTH-1:WIDTH] != '0);

  // Restoring step: quotient bits shift into lo, remainder lives in acc
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nx, div_q_nx, quo_fx, rem_fx;

  assign div_shift  = {acc_q, lo_q[WIDTH-1]};
  assign div_ge     = div_shift >= {1'b0, mag_q};
  assign div_rem_nx = div_ge ? (div_shift[WIDTH-1:0] - mag_q) : div_shift[WIDTH-1:0];
  assign div_q_nx   = {lo_q[WIDTH-2:0], div_ge};
  assign quo_fx     = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_q_nx : div_q_nx;
  assign rem_fx     = (sgn_q && a_q[WIDTH-1]) ? -div_rem_nx : div_rem_nx;

  always_comb begin
    state_d     = state_q;
    sgn_d       = sgn_q;
    a_d         = a_q;
    b_d         = b_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    hi_d        = hi_q;
    co_d        = co_q;
    ov_d        = ov_q;
    zero_d      = zero_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (alu_io.in_valid) begin
          sgn_d  = in_sgn;
          a_d    = alu_io.op_a;
          b_d    = alu_io.op_b;
          acc_d  = '0;
          cnt_d  = CW'(WIDTH);
          case (alu_io.cmd)
            C_MULT, C_MULTU: begin
              state_d = S_MUL;
              mag_d   = mag_a_in;
              lo_d    = mag_b_in;
            end
            C_DIV, C_DIVU: begin
              state_d = S_DIV;
              mag_d   = mag_b_in;
              lo_d    = mag_a_in;
            end
            default: begin
              state_d     = S_DONE;
              out_valid_d = 1'b1;
              result_d    = alu_res;
              hi_d        = '0;
              co_d        = alu_co;
              ov_d        = alu_ov;
              zero_d      = ~alu_io.cmd[3] && (alu_res == '0);
              dbz_d       = 1'b0;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = prod_fx[WIDTH-1:0];
          hi_d        = prod_fx[2*WIDTH-1:WIDTH];
          co_d        = 1'b0;
          ov_d        = mul_ov;
          zero_d      = (prod_fx[WIDTH-1:0] == '0);
          dbz_d       = 1'b0;
        end
      end
      S_DIV: begin
        acc_d = div_rem_nx;
        lo_d  = div_q_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          co_d        = 1'b0;
          if (b_q == '0) begin
            result_d = '1;
            hi_d     = a_q;
            ov_d     = 1'b0;
            zero_d   = 1'b0;
            dbz_d    = 1'b1;
          end else begin
            result_d = quo_fx;
            hi_d     = rem_fx;
            ov_d     = sgn_q && (a_q == MIN_V) && (b_q == '1);
            zero_d   = (quo_fx == '0);
            dbz_d    = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (alu_io.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sgn_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mag_q       <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      co_q        <= 1'b0;
      ov_q        <= 1'b0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sgn_q       <= sgn_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      co_q        <= co_d;
      ov_q        <= ov_d;
      zero_q      <= zero_d;
      dbz_q       <= dbz_d;
    end
  end

  assign alu_io.in_ready    = (state_q == S_IDLE);
  assign alu_io.out_valid   = out_valid_q;
  assign alu_io.result      = result_q;
  assign alu_io.hi          = hi_q;
  assign alu_io.carryout    = co_q;
  assign alu_io.overflow    = ov_q;
  assign alu_io.zero        = zero_q;
  assign alu_io.div_by_zero = dbz_q;

endmodule
